// File: rtl/nibble_serial_add16_pkg.sv
// Shared constants for the nibble-serial adder: slice width, default operand
// width and the controller state encodings.
package nibble_serial_add16_pkg;

    localparam int NIB_W     = 4;
    localparam int W_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/nibble_serial_add16_rca.sv
// 4-bit ripple-carry adder used as the per-cycle slice adder.
module rca_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = carry[4];

endmodule

// File: rtl/nibble_serial_add16.sv
// Nibble-serial adder: adds A+B+C_in one 4-bit slice per cycle and reports
// sum, carry-out and signed overflow with a one-cycle done pulse.
module nibble_serial_add16
    import nibble_serial_add16_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int NIB = NIB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         C_out,
    output logic         Ofl
);

    localparam int NSLICE = W / NIB;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    logic [1:0]      state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [W-1:0]    s_reg;
    logic            c_out_reg;
    logic            ofl_reg;

    logic [NIB-1:0]  nib_a;
    logic [NIB-1:0]  nib_b;
    logic [NIB-1:0]  nib_sum;
    logic            nib_carry;
    logic            accept;

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        nib_a = a_reg[idx*NIB +: NIB];
        nib_b = b_reg[idx*NIB +: NIB];
    end

    rca_4b u_rca (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry),
        .sum   (nib_sum),
        .c_out (nib_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                ST_RUN:  if (idx == LAST_IDX) state <= ST_DONE;
                ST_DONE: state <= start ? ST_RUN : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operands are captured only on an accepted start so later input
    // activity (including start during RUN) cannot disturb the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            s_reg     <= '0;
            c_out_reg <= 1'b0;
            ofl_reg   <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            carry <= C_in;
            idx   <= '0;
            s_reg <= '0;
        end else if (state == ST_RUN) begin
            s_reg[idx*NIB +: NIB] <= nib_sum;
            carry <= nib_carry;
            idx   <= idx + 1'b1;
            if (idx == LAST_IDX) begin
                c_out_reg <= nib_carry;
                ofl_reg   <= (a_reg[W-1] == b_reg[W-1]) && (nib_sum[NIB-1] != a_reg[W-1]);
            end
        end
    end

    assign ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign S     = s_reg;
    assign C_out = c_out_reg;
    assign Ofl   = ofl_reg;

endmodule

// File: tb/tb_nibble_serial_add16.sv
// Directed-vector and random bench for nibble_serial_add16.
module tb_nibble_serial_add16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ofl;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        C_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        C_out;
    logic        Ofl;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[8];

    nibble_serial_add16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .C_in  (C_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C_out (C_out),
        .Ofl   (Ofl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts cycles from the accept edge; the accept cycle's successor is 1.
    task automatic waitDone(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                checkOutput("busy_in_run", {31'b0, busy}, 32'd1);
                checkOutput("ready_in_run", {31'b0, ready}, 32'd0);
            end
            if (done) begin
                lat = i + 1;
                break;
            end
        end
        if (lat == 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; drives a start that is accepted on the next edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin, output int lat);
        A     = a;
        B     = b;
        C_in  = cin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = ~a;
        B     = a ^ b;
        C_in  = ~cin;
        waitDone(lat);
    endtask

    task automatic checkResult(input string name, input logic [15:0] s, input logic cout, input logic ofl);
        checkOutput({name, "_S"}, {16'b0, S}, {16'b0, s});
        checkOutput({name, "_C_out"}, {31'b0, C_out}, {31'b0, cout});
        checkOutput({name, "_Ofl"}, {31'b0, Ofl}, {31'b0, ofl});
    endtask

    initial begin
        int lat;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] full;
        logic        rofl;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        C_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'b0, ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkResult("rst", 16'h0000, 1'b0, 1'b0);

        // First start is presented as reset releases and must be taken on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 32'd5);
            checkResult($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].ofl);
            checkOutput($sformatf("vec%0d_ready_at_done", i), {31'b0, ready}, 32'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
            checkResult($sformatf("vec%0d_hold", i), vecs[i].s, vecs[i].cout, vecs[i].ofl);
            @(negedge clk);
        end

        // Back-to-back with start held high and junk operands during RUN.
        A     = 16'h1111;
        B     = 16'h0101;
        C_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        A    = 16'hFFFF;
        B    = 16'hFFFF;
        C_in = 1'b1;
        waitDone(lat);
        checkOutput("b2b_first_latency", lat, 32'd5);
        checkResult("b2b_first", 16'h1212, 1'b0, 1'b0);
        A    = 16'h0F00;
        B    = 16'h0100;
        C_in = 1'b1;
        @(posedge clk);
        #1;
        A    = 16'h0000;
        B    = 16'h0000;
        C_in = 1'b0;
        waitDone(lat);
        checkOutput("b2b_second_latency", lat, 32'd5);
        checkResult("b2b_second", 16'h1001, 1'b0, 1'b0);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b_idle_done", {31'b0, done}, 32'd0);
        checkOutput("b2b_idle_ready", {31'b0, ready}, 32'd1);
        checkResult("b2b_hold", 16'h1001, 1'b0, 1'b0);

        // Set C_out/Ofl high, then abort a later operation mid-run with reset.
        @(negedge clk);
        applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
        checkResult("pre_abort", 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        A     = 16'h1111;
        B     = 16'h2222;
        C_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_partial_S", {16'b0, S}, 32'h0033);
        rst_n = 1'b0;
        #1;
        checkResult("abort_rst", 16'h0000, 1'b0, 1'b0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_ready", {31'b0, ready}, 32'd1);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) lat++;
        end
        checkOutput("abort_no_done", lat, 32'd0);
        @(negedge clk);
        applyStimulus(16'h1234, 16'h4321, 1'b1, lat);
        checkOutput("after_abort_latency", lat, 32'd5);
        checkResult("after_abort", 16'h5556, 1'b0, 1'b0);

        // Random operands against a behavioural reference.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            rofl = (ra[15] == rb[15]) && (full[15] != ra[15]);
            applyStimulus(ra, rb, rc, lat);
            checkOutput("rand_sum", {15'b0, C_out, S}, {15'b0, full});
            checkOutput("rand_ofl", {31'b0, Ofl}, {31'b0, rofl});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
